// File: rtl/counter_checker.sv
// Receive-side checker for a free-running up/down counter stream.
// Locks after SYNC_LEN correct steps, then pulses err on every sequence break.
module counter_checker #(
   parameter int WIDTH    = 8,
   parameter int INC_DEC  = 1,
   parameter int SYNC_LEN = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] cnt,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [WIDTH-1:0] exp_val,
   output logic [WIDTH-1:0] got_val
);

   // state  | meaning
   // IDLE   | no reference sample yet
   // SYNC   | counting consecutive correct steps toward lock
   // LOCKED | tracking; any mismatch pulses err and drops back to SYNC
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
   localparam logic [ERR_W-1:0] ONE_E  = ERR_W'(1);
   localparam logic [3:0]       SYNC_N = 4'(SYNC_LEN);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [3:0]       hits_q, hits_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0] exp_val_q, exp_val_d;
   logic [WIDTH-1:0] got_val_q, got_val_d;
   logic [WIDTH-1:0] pred;
   logic             hit;

   assign pred = (INC_DEC != 0) ? prev_q + ONE_W : prev_q - ONE_W;
   assign hit  = (cnt == pred);

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      hits_d    = hits_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      exp_val_d = exp_val_q;
      got_val_d = got_val_q;
      if (clr) begin
         state_d   = IDLE;
         prev_d    = '0;
         hits_d    = '0;
         err_cnt_d = '0;
         exp_val_d = '0;
         got_val_d = '0;
      end else if (en) begin
         prev_d = cnt;
         case (state_q)
            IDLE: begin
               hits_d  = '0;
               state_d = SYNC;
            end
            SYNC: begin
               if (hit) begin
                  hits_d = hits_q + 4'd1;
                  if (hits_q + 4'd1 == SYNC_N) state_d = LOCKED;
               end else begin
                  hits_d = '0;
               end
            end
            LOCKED: begin
               if (!hit) begin
                  err_d     = 1'b1;
                  exp_val_d = pred;
                  got_val_d = cnt;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ONE_E;
                  hits_d    = '0;
                  state_d   = SYNC;
               end
            end
            default: begin
               hits_d  = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         prev_q    <= '0;
         hits_q    <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         exp_val_q <= '0;
         got_val_q <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         hits_q    <= hits_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         exp_val_q <= exp_val_d;
         got_val_q <= got_val_d;
      end
   end

   assign locked  = (state_q == LOCKED);
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign exp_val = exp_val_q;
   assign got_val = got_val_q;

endmodule
